// File: rtl/ghist_sram_1r1w.sv
// ghist_sram_1r1w: one-read/one-write history SRAM with per-entry valid bits,
// flush, optional write-first bypass, 1- or 2-cycle read latency and a sticky
// out-of-range error flag.
module ghist_sram_1r1w #(
  parameter int DEPTH        = 40,
  parameter int WIDTH        = 72,
  parameter int READ_LATENCY = 1,
  parameter int BYPASS       = 1,
  localparam int AW          = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [AW-1:0]    R0_addr,
  input  logic             R0_en,
  output logic [WIDTH-1:0] R0_data,
  output logic             R0_valid,
  output logic             R0_resp,
  input  logic [AW-1:0]    W0_addr,
  input  logic             W0_en,
  input  logic [WIDTH-1:0] W0_data,
  input  logic             flush,
  output logic             oor_err
);

  localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid;

  logic             rd_in;
  logic             wr_in;
  logic             wr_do;
  logic             hit;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;

  // Final-stage inputs: either the raw lookup (latency 1) or the stage register.
  logic             fin_en;
  logic [WIDTH-1:0] fin_data;
  logic             fin_valid;

  assign rd_in = ({1'b0, R0_addr} < LIMIT);
  assign wr_in = ({1'b0, W0_addr} < LIMIT);
  assign wr_do = W0_en && wr_in;
  assign hit   = (BYPASS != 0) && wr_do && rd_in && (W0_addr == R0_addr);

  // Lookup as of before the current edge; a same-address write overrides when bypassing.
  always_comb begin
    rd_data  = '0;
    rd_valid = 1'b0;
    if (hit) begin
      rd_data  = W0_data;
      rd_valid = 1'b1;
    end else if (rd_in && valid[R0_addr]) begin
      rd_data  = mem[R0_addr];
      rd_valid = 1'b1;
    end
  end

  // Storage array: written on in-range writes only, never reset.
  always_ff @(posedge clock) begin
    if (wr_do) mem[W0_addr] <= W0_data;
  end

  // Valid bits: flush clears all, a write on the same edge still sets its entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
    end else begin
      if (flush) valid <= '0;
      if (wr_do) valid[W0_addr] <= 1'b1;
    end
  end

  // Sticky out-of-range flag for either port.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      oor_err <= 1'b0;
    end else if ((W0_en && !wr_in) || (R0_en && !rd_in)) begin
      oor_err <= 1'b1;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic             s_en;
      logic [WIDTH-1:0] s_data;
      logic             s_valid;

      // Extra pipeline stage holding the lookup result for one cycle.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          s_en    <= 1'b0;
          s_data  <= '0;
          s_valid <= 1'b0;
        end else begin
          s_en    <= R0_en;
          s_data  <= rd_data;
          s_valid <= rd_valid;
        end
      end

      assign fin_en    = s_en;
      assign fin_data  = s_data;
      assign fin_valid = s_valid;
    end else begin : g_lat1
      assign fin_en    = R0_en;
      assign fin_data  = rd_data;
      assign fin_valid = rd_valid;
    end
  endgenerate

  // Output register: pulses resp per result and holds data between results.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      R0_resp  <= 1'b0;
      R0_data  <= '0;
      R0_valid <= 1'b0;
    end else begin
      R0_resp <= fin_en;
      if (fin_en) begin
        R0_data  <= fin_data;
        R0_valid <= fin_valid;
      end
    end
  end

endmodule

// File: tb/tb_ghist_sram_1r1w.sv
// Bench for ghist_sram_1r1w: two instances (latency 1 write-first, latency 2
// read-old) share one stimulus stream and are checked every cycle against an
// array-based reference, with a few literal checks at key points.
module tb_ghist_sram_1r1w;

  logic        clock;
  logic        reset_n;
  logic [5:0]  R0_addr;
  logic        R0_en;
  logic [5:0]  W0_addr;
  logic        W0_en;
  logic [71:0] W0_data;
  logic        flush;

  logic [71:0] a_data, b_data;
  logic        a_valid, b_valid, a_resp, b_resp, a_oor, b_oor;

  int total = 0;
  int bad   = 0;

  ghist_sram_1r1w dut_a (
    .clock(clock), .reset_n(reset_n),
    .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(a_data), .R0_valid(a_valid),
    .R0_resp(a_resp), .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data),
    .flush(flush), .oor_err(a_oor)
  );

  ghist_sram_1r1w #(.DEPTH(40), .WIDTH(72), .READ_LATENCY(2), .BYPASS(0)) dut_b (
    .clock(clock), .reset_n(reset_n),
    .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(b_data), .R0_valid(b_valid),
    .R0_resp(b_resp), .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data),
    .flush(flush), .oor_err(b_oor)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference state
  logic [71:0] m_mem [64];
  logic        m_val [64];
  logic [71:0] ea_data, eb_data, pb_data;
  logic        ea_valid, eb_valid, pb_valid;
  logic        ea_resp, eb_resp, pb_resp;
  logic        e_oor;

  initial begin
    ea_data = '0; ea_valid = 0; ea_resp = 0;
    eb_data = '0; eb_valid = 0; eb_resp = 0;
    pb_data = '0; pb_valid = 0; pb_resp = 0;
    e_oor = 0;
    for (int i = 0; i < 64; i++) m_val[i] = 1'b0;
  end

  // Reference update at each edge, then compare both instances just after it.
  always @(posedge clock) begin
    logic        rin, win, ov, hit;
    logic [71:0] od;
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) m_val[i] = 1'b0;
      ea_data = '0; ea_valid = 0; ea_resp = 0;
      eb_data = '0; eb_valid = 0; eb_resp = 0;
      pb_data = '0; pb_valid = 0; pb_resp = 0;
      e_oor = 0;
    end else begin
      rin = R0_addr < 6'd40;
      win = W0_addr < 6'd40;
      ov  = rin && m_val[R0_addr];
      od  = ov ? m_mem[R0_addr] : '0;
      hit = W0_en && win && rin && (W0_addr == R0_addr);
      // latency 1, write-first
      ea_resp = R0_en;
      if (R0_en) begin
        ea_data  = hit ? W0_data : od;
        ea_valid = hit ? 1'b1 : ov;
      end
      // latency 2, read-old: emit the previous edge's result, queue this one
      eb_resp = pb_resp;
      if (pb_resp) begin
        eb_data  = pb_data;
        eb_valid = pb_valid;
      end
      pb_resp = R0_en; pb_data = od; pb_valid = ov;
      if (flush) for (int i = 0; i < 64; i++) m_val[i] = 1'b0;
      if (W0_en && win) begin
        m_mem[W0_addr] = W0_data;
        m_val[W0_addr] = 1'b1;
      end
      if ((W0_en && !win) || (R0_en && !rin)) e_oor = 1'b1;
    end
    #1;
    chk("a_resp",  72'(a_resp),  72'(ea_resp));
    chk("a_valid", 72'(a_valid), 72'(ea_valid));
    chk("a_data",  a_data,       ea_data);
    chk("a_oor",   72'(a_oor),   72'(e_oor));
    chk("b_resp",  72'(b_resp),  72'(eb_resp));
    chk("b_valid", 72'(b_valid), 72'(eb_valid));
    chk("b_data",  b_data,       eb_data);
    chk("b_oor",   72'(b_oor),   72'(e_oor));
  end

  // Apply one cycle of inputs (called at a falling edge), wait for the next falling edge.
  task automatic step(input logic ren, input logic [5:0] ra, input logic wen,
                      input logic [5:0] wa, input logic [71:0] wd, input logic fl);
    R0_en = ren; R0_addr = ra; W0_en = wen; W0_addr = wa; W0_data = wd; flush = fl;
    @(negedge clock);
  endtask

  task automatic idle();
    step(1'b0, 6'd0, 1'b0, 6'd0, 72'd0, 1'b0);
  endtask

  logic [71:0] pat_a5;
  logic [95:0] rnd;

  initial begin
    pat_a5 = {9{8'hA5}};
    reset_n = 1'b0;
    R0_en = 0; R0_addr = '0; W0_en = 0; W0_addr = '0; W0_data = '0; flush = 0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Read of an untouched entry after reset
    step(1'b1, 6'd5, 1'b0, 6'd0, 72'd0, 1'b0);
    chk("rst_read_a_resp", 72'(a_resp), 72'd1);
    chk("rst_read_a_valid", 72'(a_valid), 72'd0);
    chk("rst_read_a_data", a_data, 72'd0);
    chk("rst_read_b_resp_early", 72'(b_resp), 72'd0);
    idle();
    chk("rst_read_b_resp", 72'(b_resp), 72'd1);
    chk("rst_read_b_valid", 72'(b_valid), 72'd0);
    chk("rst_read_a_resp_drop", 72'(a_resp), 72'd0);

    // Write 39, read back, flush, read again
    step(1'b0, 6'd0, 1'b1, 6'd39, pat_a5, 1'b0);
    step(1'b1, 6'd39, 1'b0, 6'd0, 72'd0, 1'b0);
    chk("wr39_a_data", a_data, pat_a5);
    chk("wr39_a_valid", 72'(a_valid), 72'd1);
    chk("wr39_model", ea_data, pat_a5);
    idle();
    chk("wr39_b_data", b_data, pat_a5);
    step(1'b0, 6'd0, 1'b0, 6'd0, 72'd0, 1'b1);
    step(1'b1, 6'd39, 1'b0, 6'd0, 72'd0, 1'b0);
    chk("flush39_a_valid", 72'(a_valid), 72'd0);
    chk("flush39_a_data", a_data, 72'd0);
    idle();

    // Same-edge write+read collision on address 7
    step(1'b0, 6'd0, 1'b1, 6'd7, 72'h11, 1'b0);
    step(1'b1, 6'd7, 1'b1, 6'd7, 72'h22, 1'b0);
    chk("coll_a_bypass", a_data, 72'h22);
    idle();
    chk("coll_b_old", b_data, 72'h11);
    chk("coll_model_b", eb_data, 72'h11);

    // Latency-2 back-to-back reads of 0,1,2
    for (int i = 0; i < 3; i++) step(1'b0, 6'd0, 1'b1, 6'(i), 72'(i), 1'b0);
    step(1'b1, 6'd0, 1'b0, 6'd0, 72'd0, 1'b0);
    chk("pipe_b_none", 72'(b_resp), 72'd0);
    step(1'b1, 6'd1, 1'b0, 6'd0, 72'd0, 1'b0);
    chk("pipe_b0_resp", 72'(b_resp), 72'd1);
    chk("pipe_b0_data", b_data, 72'd0);
    step(1'b1, 6'd2, 1'b0, 6'd0, 72'd0, 1'b0);
    chk("pipe_b1_resp", 72'(b_resp), 72'd1);
    chk("pipe_b1_data", b_data, 72'd1);
    idle();
    chk("pipe_b2_resp", 72'(b_resp), 72'd1);
    chk("pipe_b2_data", b_data, 72'd2);
    idle();
    chk("pipe_hold_resp", 72'(b_resp), 72'd0);
    chk("pipe_hold_data", b_data, 72'd2);

    // Out-of-range write and read
    chk("oor_clear", 72'(a_oor), 72'd0);
    step(1'b1, 6'd50, 1'b1, 6'd45, pat_a5, 1'b0);
    chk("oor_a_data", a_data, 72'd0);
    chk("oor_a_valid", 72'(a_valid), 72'd0);
    chk("oor_set", 72'(a_oor), 72'd1);
    step(1'b1, 6'd5, 1'b0, 6'd0, 72'd0, 1'b0);
    chk("oor_no_alias", 72'(a_valid), 72'd0);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      rnd = {$urandom(), $urandom(), $urandom()};
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0) ? 6'($urandom_range(40, 63)) : 6'($urandom_range(0, 39)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0) ? 6'($urandom_range(40, 63)) : 6'($urandom_range(0, 39)),
           rnd[71:0],
           $urandom_range(0, 19) == 0);
    end
    chk("oor_sticky", 72'(a_oor), 72'd1);

    // Reset asserted mid-cycle with reads in flight
    R0_en = 1'b1; R0_addr = 6'd3; W0_en = 1'b0; flush = 1'b0;
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_a_resp", 72'(a_resp), 72'd0);
    chk("arst_a_data", a_data, 72'd0);
    chk("arst_b_resp", 72'(b_resp), 72'd0);
    chk("arst_b_valid", 72'(b_valid), 72'd0);
    chk("arst_oor", 72'(b_oor), 72'd0);
    @(negedge clock);
    R0_en = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    idle();
    chk("arst_release_b", 72'(b_resp), 72'd0);
    idle();
    chk("arst_release_b2", 72'(b_resp), 72'd0);
    repeat (2) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
